// File: rtl/riscv_wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback pipeline owns the port,
// long-latency results wait in a small FIFO and use free cycles. A result
// that is denied for too long forces a one-cycle pipeline stall to drain it.
module riscv_wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_lu_valid,
  output logic            o_lu_ready,
  input  logic [4:0]      i_lu_addr,
  input  logic [XLEN-1:0] i_lu_data,
  output logic            o_rf_wr_en,
  output logic [4:0]      o_rf_wr_addr,
  output logic [XLEN-1:0] o_rf_wr_data,
  output logic            o_pipe_stall,
  output logic [31:0]     o_pending_mask
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [4:0]      fifo_addr_q [DEPTH];
  logic [4:0]      fifo_addr_d [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_data_d [DEPTH];

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            wb_req;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;
  logic [31:0]     entry_mask [DEPTH];

  // FIFO status, acceptance and head view; all derived from registered state
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    o_lu_ready = !full;
    push       = i_lu_valid && !full;
    wb_req     = i_wb_en && (i_wb_addr != 5'd0);
    head_addr  = fifo_addr_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
  end

  // Port grant and IDLE/FORCE next-state; a x0 head is popped without writing
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    o_rf_wr_en   = 1'b0;
    o_rf_wr_addr = 5'd0;
    o_rf_wr_data = '0;
    o_pipe_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_req) begin
          o_rf_wr_en   = 1'b1;
          o_rf_wr_addr = i_wb_addr;
          o_rf_wr_data = i_wb_data;
        end else if (!empty) begin
          pop          = 1'b1;
          o_rf_wr_en   = (head_addr != 5'd0);
          o_rf_wr_addr = head_addr;
          o_rf_wr_data = head_data;
        end
        if (!empty && !pop && (wait_q == WW'(MAX_WAIT - 1))) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        // Pipeline inputs are ignored; it re-presents them after the stall
        o_pipe_stall = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          o_rf_wr_en   = (head_addr != 5'd0);
          o_rf_wr_addr = head_addr;
          o_rf_wr_data = head_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait counter: how long the current head has been denied, saturating
  always_comb begin
    wait_d = wait_q;
    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // FIFO pointer, occupancy and storage updates
  always_comb begin
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d     = count_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) begin
      fifo_addr_d[wr_ptr_q] = i_lu_addr;
      fifo_data_d[wr_ptr_q] = i_lu_data;
    end
  end

  // Per-entry one-hot destination, only for occupied slots and never for x0
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offs;
      logic          occupied;
      assign offs     = AW'(gi) - rd_ptr_q;
      assign occupied = (CW'(offs) < count_q);
      assign entry_mask[gi] = (occupied && (fifo_addr_q[gi] != 5'd0))
                              ? (32'd1 << fifo_addr_q[gi]) : 32'd0;
    end
  endgenerate

  // Pending-destination mask: OR over all occupied entries
  always_comb begin
    o_pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      o_pending_mask = o_pending_mask | entry_mask[i];
    end
  end

  // Control state register; reset drops any buffered results
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers and count
  always_ff @(posedge i_clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// Directed bench for riscv_wb_port_arbiter: stimulus pushes the expected
// per-cycle outputs into a queue; a negedge monitor pops and compares.
module tb_riscv_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        pipe_stall;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit          chk;
    bit          en;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          stall;
    bit          ready;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  riscv_wb_port_arbiter #(.XLEN(32), .DEPTH(2), .MAX_WAIT(4)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_wb_en        (wb_en),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .i_lu_valid     (lu_valid),
    .o_lu_ready     (lu_ready),
    .i_lu_addr      (lu_addr),
    .i_lu_data      (lu_data),
    .o_rf_wr_en     (rf_wr_en),
    .o_rf_wr_addr   (rf_wr_addr),
    .o_rf_wr_data   (rf_wr_data),
    .o_pipe_stall   (pipe_stall),
    .o_pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cyc++;
      if (mon_e.chk) begin
        cmp("wr_en", {31'd0, rf_wr_en}, {31'd0, mon_e.en});
        if (mon_e.en) begin
          cmp("wr_addr", {27'd0, rf_wr_addr}, {27'd0, mon_e.addr});
          cmp("wr_data", rf_wr_data, mon_e.data);
        end
        cmp("stall", {31'd0, pipe_stall}, {31'd0, mon_e.stall});
        cmp("lu_ready", {31'd0, lu_ready}, {31'd0, mon_e.ready});
        cmp("pending_mask", pending_mask, mon_e.mask);
        $display("cycle %0d: wr_en=%0b x%0d=0x%08h stall=%0b ready=%0b mask=0x%08h",
                 cyc, rf_wr_en, rf_wr_addr, rf_wr_data, pipe_stall, lu_ready, pending_mask);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input bit chk, input bit en, input logic [4:0] ea, input logic [31:0] ed,
                      input bit st, input bit rdy, input logic [31:0] msk);
    exp_t e;
    @(posedge clk);
    #1;
    rstn     = r;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    lu_valid = lv;
    lu_addr  = la;
    lu_data  = ld;
    e.chk = chk; e.en = en; e.addr = ea; e.data = ed;
    e.stall = st; e.ready = rdy; e.mask = msk;
    exp_q.push_back(e);
  endtask

  localparam logic [31:0] B3  = 32'h1 << 3;
  localparam logic [31:0] B4  = 32'h1 << 4;
  localparam logic [31:0] B7  = 32'h1 << 7;
  localparam logic [31:0] B8  = 32'h1 << 8;
  localparam logic [31:0] B9  = 32'h1 << 9;
  localparam logic [31:0] B10 = 32'h1 << 10;
  localparam logic [31:0] B11 = 32'h1 << 11;
  localparam logic [31:0] B12 = 32'h1 << 12;
  localparam logic [31:0] B13 = 32'h1 << 13;
  localparam logic [31:0] B14 = 32'h1 << 14;

  initial begin
    rstn = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;

    // Reset, then check reset outputs while still held
    step(0, 0,0,0, 0,0,0,  0, 0,0,0, 0,1,0);
    step(0, 0,0,0, 0,0,0,  1, 0,0,0, 0,1,0);

    // Pipeline write with empty FIFO: same-cycle write
    step(1, 1,5,32'hDEADBEEF, 0,0,0,  1, 1,5,32'hDEADBEEF, 0,1,0);

    // Push x7 with idle pipeline: written next cycle, mask bit 7 for one cycle
    step(1, 0,0,0, 1,7,32'h11,  1, 0,0,0, 0,1,0);
    step(1, 0,0,0, 0,0,0,       1, 1,7,32'h11, 0,1,B7);
    step(1, 0,0,0, 0,0,0,       1, 0,0,0, 0,1,0);

    // Push x9 with pipeline busy every cycle: forced drain in cycle 5
    step(1, 1,1,32'h1000, 1,9,32'h99, 1, 1,1,32'h1000, 0,1,0);
    step(1, 1,1,32'h1001, 0,0,0,      1, 1,1,32'h1001, 0,1,B9);
    step(1, 1,1,32'h1002, 0,0,0,      1, 1,1,32'h1002, 0,1,B9);
    step(1, 1,1,32'h1003, 0,0,0,      1, 1,1,32'h1003, 0,1,B9);
    step(1, 1,1,32'h1004, 0,0,0,      1, 1,1,32'h1004, 0,1,B9);
    step(1, 1,1,32'h1005, 0,0,0,      1, 1,9,32'h99,   1,1,B9);
    step(1, 1,1,32'h1006, 0,0,0,      1, 1,1,32'h1006, 0,1,0);
    step(1, 0,0,0, 0,0,0,             1, 0,0,0, 0,1,0);

    // Fill the FIFO with the port busy; third offer refused until a pop
    step(1, 1,2,32'h2000, 1,10,32'hA0, 1, 1,2,32'h2000, 0,1,0);
    step(1, 1,2,32'h2001, 1,11,32'hB0, 1, 1,2,32'h2001, 0,1,B10);
    step(1, 1,2,32'h2002, 1,12,32'hC0, 1, 1,2,32'h2002, 0,0,B10|B11);
    step(1, 0,0,0,        1,12,32'hC0, 1, 1,10,32'hA0,  0,0,B10|B11);
    step(1, 0,0,0,        1,12,32'hC0, 1, 1,11,32'hB0,  0,1,B11);
    step(1, 0,0,0,        0,0,0,       1, 1,12,32'hC0,  0,1,B12);
    step(1, 0,0,0,        0,0,0,       1, 0,0,0, 0,1,0);

    // x0 filtering: pipeline x0 lets head x3 through; head x0 dropped silently
    step(1, 0,0,0,          1,3,32'h33, 1, 0,0,0, 0,1,0);
    step(1, 1,0,32'hFFFF,   0,0,0,      1, 1,3,32'h33, 0,1,B3);
    step(1, 0,0,0,          1,0,32'h55, 1, 0,0,0, 0,1,0);
    step(1, 0,0,0,          0,0,0,      1, 0,0,0, 0,1,0);
    step(1, 0,0,0,          1,4,32'h44, 1, 0,0,0, 0,1,0);
    step(1, 0,0,0,          0,0,0,      1, 1,4,32'h44, 0,1,B4);

    // Same-address conflict: pipeline wins, head stays for the next free cycle
    step(1, 0,0,0,         1,8,32'h80, 1, 0,0,0, 0,1,0);
    step(1, 1,8,32'h800,   0,0,0,      1, 1,8,32'h800, 0,1,B8);
    step(1, 0,0,0,         0,0,0,      1, 1,8,32'h80,  0,1,B8);
    step(1, 0,0,0,         0,0,0,      1, 0,0,0, 0,1,0);

    // Two pending, reach FORCE, reset during FORCE: buffered results discarded
    step(1, 1,1,32'h3000, 1,13,32'hD0, 1, 1,1,32'h3000, 0,1,0);
    step(1, 1,1,32'h3001, 1,14,32'hE0, 1, 1,1,32'h3001, 0,1,B13);
    step(1, 1,1,32'h3002, 0,0,0,       1, 1,1,32'h3002, 0,0,B13|B14);
    step(1, 1,1,32'h3003, 0,0,0,       1, 1,1,32'h3003, 0,0,B13|B14);
    step(1, 1,1,32'h3004, 0,0,0,       1, 1,1,32'h3004, 0,0,B13|B14);
    step(0, 1,1,32'h3005, 0,0,0,       1, 1,13,32'hD0,  1,0,B13|B14);
    step(1, 0,0,0, 0,0,0,              1, 0,0,0, 0,1,0);
    step(1, 0,0,0, 0,0,0,              1, 0,0,0, 0,1,0);
    step(1, 0,0,0, 0,0,0,              1, 0,0,0, 0,1,0);
    step(1, 0,0,0, 0,0,0,              1, 0,0,0, 0,1,0);

    // Let the monitor consume the last expectation
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
